// File: rtl/exc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : exc_pkg
// Brief    : Exception codes, FSM states and vector constants for exc_ctrl.
// Revision : 1.0
// ============================================================================
package exc_pkg;

    typedef enum logic [4:0] {
        INT  = 5'd0,
        ADEL = 5'd4,
        ADES = 5'd5,
        SYS  = 5'd8,
        BP   = 5'd9,
        RI   = 5'd10,
        CPU  = 5'd11,
        OV   = 5'd12
    } exc_code_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REDIR = 2'd1,
        ST_FLUSH = 2'd2
    } exc_state_t;

    localparam logic [31:0] c_bev_base   = 32'hBFC0_0200;
    localparam logic [31:0] c_vec_offset = 32'h0000_0180;
    localparam logic [31:0] c_iv_offset  = 32'h0000_0200;

    // A delay-slot instruction restarts at its branch, one word earlier.
    function automatic logic [31:0] exc_epc(input logic [31:0] pc, input logic in_ds);
        return in_ds ? (pc - 32'd4) : pc;
    endfunction

endpackage
`default_nettype wire

// File: rtl/exc_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : exc_ctrl_if
// Brief    : Commit-stage / CP0 bundle between the pipeline and exc_ctrl.
// Revision : 1.0
// ============================================================================
interface exc_ctrl_if #(
    parameter int N_HW_IRQ = 6
);
    logic                  mem_stall;
    logic                  commit_valid;
    logic                  in_delay_slot;
    logic [31:0]           pc;
    logic [31:0]           mem_addr;
    logic                  mem_wen;
    logic                  iaddr_err;
    logic                  ri;
    logic                  cpu;
    logic                  syscall;
    logic                  break_;
    logic                  ov;
    logic                  eret;
    logic                  daddr_err;
    logic [N_HW_IRQ-1:0]   hw_irq;
    logic [1:0]            sw_irq;
    logic [N_HW_IRQ+1:0]   irq_mask;
    logic                  ie;
    logic                  exl;
    logic                  bev;
    logic                  iv;
    logic [31:0]           ebase;
    logic [31:0]           epc_in;

    logic                  redirect;
    logic [31:0]           redirect_pc;
    logic                  flush;
    logic                  cp0_exp_en;
    logic                  cp0_exl_clean;
    logic [31:0]           cp0_exp_epc;
    logic [4:0]            cp0_exp_code;
    logic                  cp0_exp_bd;
    logic [31:0]           cp0_badvaddr;
    logic                  cp0_badvaddr_wen;
    logic [N_HW_IRQ+1:0]   ip_pending;

    modport master (
        output mem_stall, commit_valid, in_delay_slot, pc, mem_addr, mem_wen,
               iaddr_err, ri, cpu, syscall, break_, ov, eret, daddr_err,
               hw_irq, sw_irq, irq_mask, ie, exl, bev, iv, ebase, epc_in,
        input  redirect, redirect_pc, flush, cp0_exp_en, cp0_exl_clean,
               cp0_exp_epc, cp0_exp_code, cp0_exp_bd, cp0_badvaddr,
               cp0_badvaddr_wen, ip_pending
    );

    modport slave (
        input  mem_stall, commit_valid, in_delay_slot, pc, mem_addr, mem_wen,
               iaddr_err, ri, cpu, syscall, break_, ov, eret, daddr_err,
               hw_irq, sw_irq, irq_mask, ie, exl, bev, iv, ebase, epc_in,
        output redirect, redirect_pc, flush, cp0_exp_en, cp0_exl_clean,
               cp0_exp_epc, cp0_exp_code, cp0_exp_bd, cp0_badvaddr,
               cp0_badvaddr_wen, ip_pending
    );
endinterface
`default_nettype wire

// File: rtl/irq_sync.sv
`default_nettype none
// ============================================================================
// Module   : irq_sync
// Brief    : Per-bit multi-flop synchroniser with async active-low reset.
// Revision : 1.0
// ============================================================================
module irq_sync #(
    parameter int WIDTH  = 6,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] r_sync [STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                r_sync[i] <= '0;
            end
        end else begin
            r_sync[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    assign q = r_sync[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/exc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : exc_ctrl
// Brief    : Commit-boundary exception/interrupt controller with registered
//            redirect, CP0 strobes and a stall-aware flush window.
// Revision : 1.0
// ============================================================================
module exc_ctrl
    import exc_pkg::*;
#(
    parameter int          N_HW_IRQ     = 6,
    parameter int          SYNC_STAGES  = 2,
    parameter int          FLUSH_CYCLES = 2,
    parameter logic [31:0] BEV_BASE     = c_bev_base,
    parameter logic [31:0] VEC_OFFSET   = c_vec_offset,
    parameter logic [31:0] IV_OFFSET    = c_iv_offset
) (
    input  logic       clk,
    input  logic       rst_n,
    exc_ctrl_if.slave  bus
);
    localparam logic [2:0] c_flush_init = 3'(FLUSH_CYCLES - 1);

    exc_state_t          r_state;
    exc_state_t          w_state_nxt;
    logic [2:0]          r_cnt;
    logic [2:0]          w_cnt_nxt;
    logic                w_accept;

    logic [N_HW_IRQ-1:0] w_hw_sync;
    logic [N_HW_IRQ+1:0] w_ip;
    logic                w_irq_req;

    logic                w_event;
    logic                w_is_exc;
    logic                w_is_eret;
    logic                w_bad_wen;
    exc_code_t           w_code;
    logic [31:0]         w_badvaddr;
    logic [31:0]         w_base;
    logic [31:0]         w_target;

    logic                r_exp_en;
    logic                r_exl_clean;
    logic                r_bad_wen;
    logic [31:0]         r_redirect_pc;
    logic [31:0]         r_epc;
    exc_code_t           r_code;
    logic                r_bd;
    logic [31:0]         r_badvaddr;

    irq_sync #(
        .WIDTH  (N_HW_IRQ),
        .STAGES (SYNC_STAGES)
    ) u_irq_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (bus.hw_irq),
        .q     (w_hw_sync)
    );

    assign w_ip      = {w_hw_sync, bus.sw_irq};
    assign w_irq_req = bus.ie & ~bus.exl & (|(w_ip & bus.irq_mask));

    // Priority decode of the committing instruction; interrupts pre-empt all.
    always_comb begin
        w_event    = 1'b1;
        w_is_exc   = 1'b1;
        w_is_eret  = 1'b0;
        w_bad_wen  = 1'b0;
        w_code     = INT;
        w_badvaddr = bus.pc;
        if (w_irq_req) begin
            w_code = INT;
        end else if (bus.iaddr_err) begin
            w_code    = ADEL;
            w_bad_wen = 1'b1;
        end else if (bus.syscall) begin
            w_code = SYS;
        end else if (bus.break_) begin
            w_code = BP;
        end else if (bus.ri) begin
            w_code = RI;
        end else if (bus.cpu) begin
            w_code = CPU;
        end else if (bus.ov) begin
            w_code = OV;
        end else if (bus.eret) begin
            w_is_exc  = 1'b0;
            w_is_eret = 1'b1;
        end else if (bus.daddr_err) begin
            w_code     = bus.mem_wen ? ADES : ADEL;
            w_bad_wen  = 1'b1;
            w_badvaddr = bus.mem_addr;
        end else begin
            w_event  = 1'b0;
            w_is_exc = 1'b0;
        end
    end

    assign w_base   = bus.bev ? BEV_BASE : bus.ebase;
    assign w_target = w_is_eret ? bus.epc_in
                    : w_base + ((w_irq_req && bus.iv) ? IV_OFFSET : VEC_OFFSET);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // FLUSH holds for FLUSH_CYCLES-1 unstalled cycles, so REDIR plus FLUSH
    // spans FLUSH_CYCLES cycles in total.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.commit_valid && !bus.mem_stall && w_event) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_REDIR;
                end
            end
            ST_REDIR: begin
                if (FLUSH_CYCLES > 1) begin
                    w_state_nxt = ST_FLUSH;
                    w_cnt_nxt   = c_flush_init;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_FLUSH: begin
                if (!bus.mem_stall) begin
                    w_cnt_nxt = r_cnt - 3'd1;
                    if (r_cnt <= 3'd1) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_exp_en      <= 1'b0;
            r_exl_clean   <= 1'b0;
            r_bad_wen     <= 1'b0;
            r_redirect_pc <= 32'h0;
            r_epc         <= 32'h0;
            r_code        <= INT;
            r_bd          <= 1'b0;
            r_badvaddr    <= 32'h0;
        end else begin
            r_exp_en    <= w_accept & w_is_exc;
            r_exl_clean <= w_accept & w_is_eret;
            r_bad_wen   <= w_accept & w_bad_wen;
            if (w_accept) begin
                r_redirect_pc <= w_target;
            end
            if (w_accept && w_is_exc) begin
                r_epc  <= exc_epc(bus.pc, bus.in_delay_slot);
                r_code <= w_code;
                r_bd   <= bus.in_delay_slot;
            end
            if (w_accept && w_bad_wen) begin
                r_badvaddr <= w_badvaddr;
            end
        end
    end

    assign bus.redirect         = (r_state == ST_REDIR);
    assign bus.flush            = (r_state != ST_IDLE);
    assign bus.redirect_pc      = r_redirect_pc;
    assign bus.cp0_exp_en       = r_exp_en;
    assign bus.cp0_exl_clean    = r_exl_clean;
    assign bus.cp0_exp_epc      = r_epc;
    assign bus.cp0_exp_code     = r_code;
    assign bus.cp0_exp_bd       = r_bd;
    assign bus.cp0_badvaddr     = r_badvaddr;
    assign bus.cp0_badvaddr_wen = r_bad_wen;
    assign bus.ip_pending       = w_ip;

endmodule
`default_nettype wire
